// File: rtl/mod_dds_pkg.sv
// Shared definitions for the modulated DDS: mode encoding and controller state encoding.
package mod_dds_pkg;

    localparam logic [1:0] MODE_CW = 2'd0;
    localparam logic [1:0] MODE_FM = 2'd1;
    localparam logic [1:0] MODE_PM = 2'd2;
    localparam logic [1:0] MODE_AM = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } dds_state_e;

endpackage

// File: rtl/mod_dds_sine_lut_q.sv
// Quarter-wave sine table, combinational read; entry k spans 0..pi/2 inclusive over the table.
module sine_lut_q #(
    parameter int LUT_AW = 8,
    parameter int LUT_DW = 14
) (
    input  logic [LUT_AW-1:0] addr,
    output logic [LUT_DW-1:0] data
);

    localparam int  DEPTH = 2 ** LUT_AW;
    localparam real PI    = 3.14159265358979323846;
    localparam real AMP   = (2.0 ** (LUT_DW - 1)) - 1.0;

    logic [LUT_DW-1:0] rom_s [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam real ANGLE = PI * k / (2.0 * (DEPTH - 1));
        assign rom_s[k] = LUT_DW'($rtoi(AMP * $sin(ANGLE) + 0.5));
    end

    assign data = rom_s[addr];

endmodule

// File: rtl/mod_dds.sv
// Phase-accumulator DDS with CW/FM/PM/AM modulation and wrap-synchronised mode switching.
module mod_dds
    import mod_dds_pkg::*;
#(
    parameter int INPUT_WIDTH  = 12,
    parameter int PHASE_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 12,
    parameter int LUT_AW       = 8,
    parameter int LUT_DW       = 14
) (
    input  logic                                  clk_in,
    input  logic                                  RST,
    input  logic signed [INPUT_WIDTH-1:0]         wave_in,
    input  logic                                  wave_valid,
    input  logic [PHASE_WIDTH-INPUT_WIDTH-1:0]    move_fre,
    input  logic [PHASE_WIDTH-1:0]                center_fre,
    input  logic [1:0]                            mode,
    input  logic                                  out_en,
    input  logic                                  phase_clr,
    output logic signed [OUTPUT_WIDTH-1:0]        FM_wave,
    output logic                                  wave_valid_out,
    output logic [1:0]                            mode_act
);

    localparam int PROD_W = PHASE_WIDTH + 1;
    localparam int SUM_W  = PHASE_WIDTH + 2;
    localparam int TOP_W  = LUT_AW + 2;
    localparam int AM_W   = OUTPUT_WIDTH + INPUT_WIDTH + 1;

    dds_state_e                    state_r, state_nxt_s;
    logic [1:0]                    mode_act_r, mode_act_nxt_s;
    logic signed [INPUT_WIDTH-1:0] wave_r;
    logic signed [PROD_W-1:0]      prod_r, wave_ext_s, gain_ext_s;
    logic signed [SUM_W-1:0]       fm_sum_s;
    logic [PHASE_WIDTH-1:0]        freq_r, freq_nxt_s, acc_r, phase_s;
    logic [PHASE_WIDTH:0]          acc_sum_s;
    logic                          wrap_s;
    logic [INPUT_WIDTH-1:0]        gain_s, gain1_r, gain2_r;
    logic [TOP_W-1:0]              phase_top_r;
    logic                          am1_r, am2_r, vld1_r, vld2_r;
    logic [LUT_AW-1:0]             lut_addr_s;
    logic [LUT_DW-1:0]             lut_data_s;
    logic signed [OUTPUT_WIDTH-1:0] mag_s, sample_s, sample_r;
    logic signed [AM_W-1:0]        am_a_s, am_b_s, am_prod_s;

    assign wave_ext_s = PROD_W'(wave_r);
    assign gain_ext_s = PROD_W'({1'b0, move_fre});
    assign fm_sum_s   = $signed({2'b00, center_fre}) + SUM_W'(prod_r);
    assign acc_sum_s  = {1'b0, acc_r} + {1'b0, freq_r};
    // A clear on the wrap cycle suppresses the wrap, so a pending switch stays pending
    assign wrap_s     = acc_sum_s[PHASE_WIDTH] & ~phase_clr;
    assign gain_s     = {~wave_r[INPUT_WIDTH-1], wave_r[INPUT_WIDTH-2:0]};
    assign phase_s    = (mode_act_r == MODE_PM) ? acc_r + prod_r[PHASE_WIDTH-1:0] : acc_r;
    assign mode_act   = mode_act_r;

    // Frequency word: saturated FM sum, otherwise the carrier word
    always_comb begin
        freq_nxt_s = center_fre;
        if (mode_act_r == MODE_FM) begin
            if (fm_sum_s[SUM_W-1]) begin
                freq_nxt_s = {PHASE_WIDTH{1'b0}};
            end else if (fm_sum_s[SUM_W-2:PHASE_WIDTH] != 1'b0) begin
                freq_nxt_s = {PHASE_WIDTH{1'b1}};
            end else begin
                freq_nxt_s = fm_sum_s[PHASE_WIDTH-1:0];
            end
        end else begin
            freq_nxt_s = center_fre;
        end
    end

    // Controller next state and applied-mode update
    always_comb begin
        state_nxt_s    = state_r;
        mode_act_nxt_s = mode_act_r;
        case (state_r)
            ST_IDLE: begin
                if (out_en) begin
                    state_nxt_s    = ST_RUN;
                    mode_act_nxt_s = mode;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!out_en) begin
                    state_nxt_s = ST_IDLE;
                end else if (mode != mode_act_r) begin
                    state_nxt_s = ST_SWITCH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_SWITCH: begin
                if (!out_en) begin
                    state_nxt_s = ST_IDLE;
                end else if (mode == mode_act_r) begin
                    state_nxt_s = ST_RUN;
                end else if (wrap_s) begin
                    state_nxt_s    = ST_RUN;
                    mode_act_nxt_s = mode;
                end else begin
                    state_nxt_s = ST_SWITCH;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                mode_act_nxt_s = MODE_CW;
            end
        endcase
    end

    // Controller, modulation front end and phase accumulator
    always_ff @(posedge clk_in) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            mode_act_r <= MODE_CW;
            wave_r     <= {INPUT_WIDTH{1'b0}};
            prod_r     <= {PROD_W{1'b0}};
            freq_r     <= {PHASE_WIDTH{1'b0}};
            acc_r      <= {PHASE_WIDTH{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            mode_act_r <= mode_act_nxt_s;
            if (wave_valid) begin
                wave_r <= wave_in;
            end else begin
                wave_r <= wave_r;
            end
            prod_r <= wave_ext_s * gain_ext_s;
            freq_r <= freq_nxt_s;
            if (!out_en || (state_r == ST_IDLE) || phase_clr) begin
                acc_r <= {PHASE_WIDTH{1'b0}};
            end else begin
                acc_r <= acc_sum_s[PHASE_WIDTH-1:0];
            end
        end
    end

    assign lut_addr_s = phase_top_r[LUT_AW-1:0] ^ {LUT_AW{phase_top_r[LUT_AW]}};

    sine_lut_q #(
        .LUT_AW (LUT_AW),
        .LUT_DW (LUT_DW)
    ) u_lut (
        .addr (lut_addr_s),
        .data (lut_data_s)
    );

    assign mag_s     = OUTPUT_WIDTH'(lut_data_s >> (LUT_DW - OUTPUT_WIDTH));
    assign sample_s  = phase_top_r[TOP_W-1] ? -mag_s : mag_s;
    assign am_a_s    = AM_W'(sample_r);
    assign am_b_s    = AM_W'({1'b0, gain2_r});
    assign am_prod_s = am_a_s * am_b_s;

    // Phase and sample stages; AM gain and validity tag travel with each sample
    always_ff @(posedge clk_in) begin
        if (RST) begin
            phase_top_r <= {TOP_W{1'b0}};
            gain1_r     <= {INPUT_WIDTH{1'b0}};
            am1_r       <= 1'b0;
            vld1_r      <= 1'b0;
            sample_r    <= {OUTPUT_WIDTH{1'b0}};
            gain2_r     <= {INPUT_WIDTH{1'b0}};
            am2_r       <= 1'b0;
            vld2_r      <= 1'b0;
        end else begin
            phase_top_r <= TOP_W'(phase_s >> (PHASE_WIDTH - TOP_W));
            gain1_r     <= gain_s;
            am1_r       <= (mode_act_r == MODE_AM);
            vld1_r      <= (state_r != ST_IDLE);
            sample_r    <= sample_s;
            gain2_r     <= gain1_r;
            am2_r       <= am1_r;
            vld2_r      <= vld1_r;
        end
    end

    // Output register: AM scaling or plain sample, forced to zero when not tagged valid
    always_ff @(posedge clk_in) begin
        if (RST) begin
            FM_wave        <= {OUTPUT_WIDTH{1'b0}};
            wave_valid_out <= 1'b0;
        end else if (!vld2_r) begin
            FM_wave        <= {OUTPUT_WIDTH{1'b0}};
            wave_valid_out <= 1'b0;
        end else if (am2_r) begin
            FM_wave        <= OUTPUT_WIDTH'(am_prod_s >>> INPUT_WIDTH);
            wave_valid_out <= 1'b1;
        end else begin
            FM_wave        <= sample_r;
            wave_valid_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mod_dds.sv
// Randomised and directed bench for mod_dds against a cycle-level arithmetic model.
module tb_mod_dds;

    localparam int     IW  = 12;
    localparam int     PW  = 32;
    localparam int     OW  = 12;
    localparam int     AW  = 8;
    localparam int     DW  = 14;
    localparam longint M32 = 64'h0000_0000_FFFF_FFFF;

    logic                  clk_in = 1'b0;
    logic                  RST;
    logic signed [IW-1:0]  wave_in;
    logic                  wave_valid;
    logic [PW-IW-1:0]      move_fre;
    logic [PW-1:0]         center_fre;
    logic [1:0]            mode;
    logic                  out_en;
    logic                  phase_clr;
    logic signed [OW-1:0]  FM_wave;
    logic                  wave_valid_out;
    logic [1:0]            mode_act;

    always #5 clk_in = ~clk_in;

    mod_dds #(
        .INPUT_WIDTH (IW), .PHASE_WIDTH (PW), .OUTPUT_WIDTH (OW),
        .LUT_AW (AW), .LUT_DW (DW)
    ) dut (
        .clk_in (clk_in), .RST (RST), .wave_in (wave_in), .wave_valid (wave_valid),
        .move_fre (move_fre), .center_fre (center_fre), .mode (mode), .out_en (out_en),
        .phase_clr (phase_clr), .FM_wave (FM_wave), .wave_valid_out (wave_valid_out),
        .mode_act (mode_act)
    );

    int     lut_m [256];
    int     n_cmp = 0;
    int     n_bad = 0;
    bit     model_ready = 1'b0;
    int     m_st, m_ma, m_wr;
    longint m_pr, m_fr, m_acc;
    int     d_val [2];
    bit     d_vld [2];
    int     exp_fm, exp_ma;
    bit     exp_vld;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint clamp32(input longint v);
        if (v < 0) return 0;
        if (v > M32) return M32;
        return v;
    endfunction

    // Sample produced from one phase/acc snapshot, following the quarter-wave rules
    function automatic int wave_of(input longint acc, input longint pr, input int ma, input int wr);
        longint ph;
        int q, idx, s;
        ph  = (ma == 2) ? ((acc + (pr & M32)) & M32) : acc;
        q   = int'(ph >> 30);
        idx = int'((ph >> 22) & 255);
        if (q % 2 == 1) idx = 255 - idx;
        s = lut_m[idx] / 4;
        if (q >= 2) s = -s;
        if (ma == 3) s = (s * (wr + 2048)) >>> 12;
        return s;
    endfunction

    // Reference model: states 0 idle, 1 run, 2 switch
    always @(posedge clk_in) begin
        int n_st, n_ma, n_wr;
        longint n_pr, n_fr, n_acc, sum;
        bit wrap, x_vld;
        int x_val;
        if (RST) begin
            m_st = 0; m_ma = 0; m_wr = 0; m_pr = 0; m_fr = 0; m_acc = 0;
            d_val[0] = 0; d_val[1] = 0; d_vld[0] = 1'b0; d_vld[1] = 1'b0;
            exp_fm = 0; exp_vld = 1'b0; exp_ma = 0;
            model_ready = 1'b1;
        end else if (model_ready) begin
            x_vld = (m_st != 0);
            x_val = x_vld ? wave_of(m_acc, m_pr, m_ma, m_wr) : 0;
            exp_fm = d_val[1]; exp_vld = d_vld[1];
            d_val[1] = d_val[0]; d_vld[1] = d_vld[0];
            d_val[0] = x_val;    d_vld[0] = x_vld;

            n_wr  = wave_valid ? int'(wave_in) : m_wr;
            n_pr  = longint'(m_wr) * longint'(move_fre);
            n_fr  = (m_ma == 1) ? clamp32(longint'(center_fre) + m_pr) : longint'(center_fre);
            sum   = m_acc + m_fr;
            wrap  = (sum > M32) && !phase_clr;
            n_acc = (!out_en || m_st == 0 || phase_clr) ? 0 : (sum & M32);
            n_st  = m_st;
            n_ma  = m_ma;
            if (!out_en) n_st = 0;
            else if (m_st == 0) begin n_st = 1; n_ma = int'(mode); end
            else if (m_st == 1) n_st = (int'(mode) != m_ma) ? 2 : 1;
            else if (int'(mode) == m_ma) n_st = 1;
            else if (wrap) begin n_st = 1; n_ma = int'(mode); end
            m_st = n_st; m_ma = n_ma; m_wr = n_wr; m_pr = n_pr; m_fr = n_fr; m_acc = n_acc;
            exp_ma = m_ma;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk_in) begin
        if (model_ready) begin
            check("fm_wave", longint'(FM_wave), longint'(exp_fm));
            check("valid", longint'(wave_valid_out), longint'(exp_vld));
            check("mode_act", longint'(mode_act), longint'(exp_ma));
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clr_pulse();
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
    endtask

    initial begin
        int cw_exp [4];
        int am_exp [4];
        cw_exp = '{0, 2047, 0, -2047};
        am_exp = '{0, 2046, 0, -2047};
        for (int k = 0; k < 256; k++)
            lut_m[k] = $rtoi(8191.0 * $sin(3.14159265358979323846 * k / 510.0) + 0.5);
        RST = 1'b1; out_en = 1'b0; phase_clr = 1'b0; mode = 2'd0;
        wave_in = '0; wave_valid = 1'b0; move_fre = '0; center_fre = '0;
        repeat (3) tick();
        check("lut_peak", lut_m[255], 8191);
        check("lut_base", lut_m[0], 0);
        check("rst_fm", longint'(FM_wave), 0);
        check("rst_vld", longint'(wave_valid_out), 0);
        check("rst_mode", longint'(mode_act), 0);

        // CW quarter-rate carrier
        RST = 1'b0; center_fre = 32'h4000_0000;
        tick();
        out_en = 1'b1;
        tick(); tick(); tick();
        check("cw_lead_vld", longint'(wave_valid_out), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cw_seq", longint'(FM_wave), cw_exp[i]);
            check("cw_seq_model", exp_fm, cw_exp[i]);
            check("cw_vld", longint'(wave_valid_out), 1);
        end

        // FM saturation high then low
        mode = 2'd1; wave_in = 12'sd2047; wave_valid = 1'b1; move_fre = 20'd1;
        center_fre = 32'hFFFF_FFF0;
        repeat (8) tick();
        check("fm_mode", longint'(mode_act), 1);
        check("fm_sat_word", m_fr, 64'h0000_0000_FFFF_FFFF);
        center_fre = 32'd100; wave_in = -12'sd2048;
        repeat (6) tick();
        check("fm_floor_word", m_fr, 0);
        clr_pulse();
        repeat (4) tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("fm_floor_out", longint'(FM_wave), 0);
        end

        // Back to CW, then deferral and cancellation of a PM request
        center_fre = 32'h4000_0000; wave_in = 12'sd0; mode = 2'd0;
        repeat (12) tick();
        check("to_cw", longint'(mode_act), 0);
        clr_pulse();
        mode = 2'd2;
        tick();
        mode = 2'd0;
        repeat (6) tick();
        check("sw_cancel", longint'(mode_act), 0);
        clr_pulse();
        mode = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("defer_hold", longint'(mode_act), 0);
        end
        tick();
        check("defer_apply", longint'(mode_act), 2);

        // AM: zero gain, then full gain aligned by a phase clear
        mode = 2'd3; wave_in = -12'sd2048; move_fre = 20'd1;
        repeat (10) tick();
        check("am_mode", longint'(mode_act), 3);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("am_zero", longint'(FM_wave), 0);
        end
        wave_in = 12'sd2047;
        repeat (3) tick();
        clr_pulse();
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("am_seq", longint'(FM_wave), am_exp[i]);
            check("am_seq_model", exp_fm, am_exp[i]);
        end

        // Reset mid-run with out_en held, then drain on out_en low
        mode = 2'd1; RST = 1'b1;
        tick();
        check("rst_run_fm", longint'(FM_wave), 0);
        check("rst_run_vld", longint'(wave_valid_out), 0);
        check("rst_run_mode", longint'(mode_act), 0);
        RST = 1'b0;
        tick();
        check("rerun_mode", longint'(mode_act), 1);
        tick(); tick();
        check("rerun_vld_lo", longint'(wave_valid_out), 0);
        tick();
        check("rerun_vld_hi", longint'(wave_valid_out), 1);
        out_en = 1'b0;
        tick(); tick(); tick();
        check("drain_vld_hi", longint'(wave_valid_out), 1);
        tick();
        check("drain_vld_lo", longint'(wave_valid_out), 0);
        check("drain_fm", longint'(FM_wave), 0);

        // Randomised operation
        out_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            wave_valid = 1'($urandom);
            wave_in    = IW'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                case ($urandom_range(0, 3))
                    0: center_fre = $urandom;
                    1: center_fre = 32'h4000_0000;
                    2: center_fre = 32'hFFFF_FFFF - 32'($urandom_range(0, 4095));
                    default: center_fre = 32'($urandom_range(0, 65535));
                endcase
            end
            if ($urandom_range(0, 31) == 0) move_fre = (PW-IW)'($urandom);
            phase_clr = ($urandom_range(0, 23) == 0);
            out_en    = ($urandom_range(0, 99) < 97);
            RST       = ($urandom_range(0, 499) == 0);
            tick();
        end
        RST = 1'b0; phase_clr = 1'b0; out_en = 1'b0;
        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_dds.md
MOD_DDS -- requirements
Module: mod_dds

Interface
REQ-001 SHALL have parameters: INPUT_WIDTH=12, modulating sample width; PHASE_WIDTH=32, accumulator width; OUTPUT_WIDTH=12, carrier output width; LUT_AW=8, quarter-wave table address width; LUT_DW=14, table word width (OUTPUT_WIDTH<=LUT_DW).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk_in, in, 1, sole clock; one clock domain; reset is synchronous and active-high.
- RST, in, 1, synchronous active-high reset.
- wave_in, in, INPUT_WIDTH, signed modulating sample.
- wave_valid, in, 1, qualifies wave_in.
- move_fre, in, PHASE_WIDTH-INPUT_WIDTH, unsigned deviation gain (FM: freq; PM: phase).
- center_fre, in, PHASE_WIDTH, unsigned carrier frequency word.
- mode, in, 2, requested mode: 0 CW, 1 FM, 2 PM, 3 AM.
- out_en, in, 1, run enable.
- phase_clr, in, 1, accumulator clear strobe.
- FM_wave, out, OUTPUT_WIDTH, signed modulated output.
- wave_valid_out, out, 1, FM_wave is a valid sample.
- mode_act, out, 2, mode currently applied.

Function
REQ-003 SHALL register wave_in into wave_r only on cycles with wave_valid=1; otherwise wave_r holds (sample-and-hold).
REQ-004 SHALL compute prod = wave_r (signed) * {0,move_fre} (unsigned), registered, at full width INPUT_WIDTH+PHASE_WIDTH-INPUT_WIDTH+1.
REQ-005 FM: frequency word SHALL be center_fre + prod, computed without loss and clamped to [0, 2^PHASE_WIDTH-1], registered; CW, PM, AM: frequency word SHALL equal center_fre.
REQ-006 Accumulator SHALL add the frequency word each RUN cycle, modulo 2^PHASE_WIDTH; it is held at 0 in IDLE.
REQ-007 PM: LUT phase SHALL be acc + prod[PHASE_WIDTH-1:0] modulo 2^PHASE_WIDTH; other modes: LUT phase SHALL equal acc.
REQ-008 Quarter-wave lookup on the top LUT_AW+2 phase bits: quadrant = top 2 bits; index = remaining bits, inverted in quadrants 1 and 3; sample = top OUTPUT_WIDTH bits of entry; negated in quadrants 2 and 3.
REQ-009 Table entry k SHALL be round((2^(LUT_DW-1)-1)*sin(pi*k/(2*(2^LUT_AW-1)))).
REQ-010 AM: output SHALL be (sample * (wave_r + 2^(INPUT_WIDTH-1))) arithmetically shifted right by INPUT_WIDTH; other modes: output SHALL be the sample.
REQ-011 Latency: the accumulator register value SHALL reach FM_wave exactly 3 cycles later (phase/LUT address register, sample register, output register).
REQ-012 FSM states: IDLE, RUN, SWITCH.
- IDLE->RUN on out_en=1; mode_act<=mode on that transition.
- RUN->SWITCH when mode!=mode_act.
- SWITCH->RUN on the cycle the accumulator wraps (new acc < old acc); mode_act<=mode on that cycle; the modulation path uses the new mode from the next cycle.
- If mode returns to mode_act while in SWITCH, SHALL go to RUN with no change.
- Any state->IDLE on out_en=0.
REQ-013 wave_valid_out SHALL be 1 exactly when the sample on FM_wave originated from a RUN/SWITCH accumulator value (3-cycle delayed state tag); otherwise FM_wave SHALL be 0.
REQ-014 phase_clr=1 SHALL load acc=0 next cycle (overriding the add); it has priority over a coincident wrap; a pending SWITCH stays pending.
REQ-015 out_en=0 SHALL clear acc to 0 next cycle; pipeline drains and wave_valid_out falls 3 cycles later.

Reset
REQ-016 RST=1 SHALL clear, next edge: wave_r, prod, frequency word, acc, pipeline, FM_wave=0, wave_valid_out=0, mode_act=0 (CW), state IDLE; this takes priority over all inputs, including mid-run.

Structure
REQ-017 Shared package mod_dds_pkg SHALL hold the mode encoding constants (MODE_CW, MODE_FM, MODE_PM, MODE_AM) and the FSM state encoding.
REQ-018 The table SHALL be a sub-module, sine_lut_q, parametrised by LUT_AW and LUT_DW, combinational read, generated from REQ-009.

Verification (defaults)
REQ-019 CW, center_fre=2^30, out_en=1 -> FM_wave repeats 0, 2047, 0, -2047; wave_valid_out=1 from the 4th cycle after RUN entry.
REQ-020 FM saturation:
- center_fre=2^32-16, move_fre=1, wave=+2047 -> word 2^32-1.
- center_fre=100, wave=-2048 -> word 0; FM_wave constant 0.
REQ-021 Mode deferral: in RUN/CW, set mode=PM mid-period -> mode_act remains 0 until the cycle after the acc wrap, then becomes 2; mode returned to CW before the wrap -> no change.
REQ-022 AM: wave=-2048 -> FM_wave=0 every cycle; wave=+2047, center_fre=2^30 -> sequence 0, 2046, 0, -2047.
REQ-023 phase_clr pulse in RUN -> acc=0 next cycle; FM_wave=0 three cycles later.
REQ-024 RST pulse mid-run -> next cycle FM_wave=0, wave_valid_out=0, mode_act=0, IDLE; out_en held 1 -> RUN re-entered the cycle after RST falls.
